extmem_arbiter: RTL and testbench
=================================

Name: extmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the external memory system (13-bit word address, shared 32-bit bidirectional data bus, byte enables, rwb/en/done).
- Shares the memory between the instruction-fetch path (read-only) and the data path (read/write with byte enables).
- Runs one transaction at a time, with round-robin grant, minimum-latency enforcement and a timeout on done.

Parameters:
MINLAT, 2, minimum ACCESS cycles before memdone is honoured (>=1)
TIMEOUT, 16, ACCESS cycles without qualified memdone before abort (>MINLAT)

Ports:
ph1  input  1  sole clock; all state updates on rising edge
reset  input  1  synchronous, active-high
ireq  input  1  instruction read request; hold until iack
iadr  input  13  instruction word address
iack  output  1  one-cycle completion pulse to instruction port
irdata  output  32  read data; valid while iack=1
dreq  input  1  data request; hold until dack
drwb  input  1  1=read, 0=write
dadr  input  13  data word address
dwdata  input  32  write data
dbyteen  input  4  write byte enables, bit0=data[7:0]
dack  output  1  one-cycle completion pulse to data port
drdata  output  32  read data; valid while dack=1
err  output  1  with iack/dack: transaction timed out
memadr  output  13  memory word address
memdata  inout  32  shared memory data bus
membyteen  output  4  memory byte enables
memrwb  output  1  memory read(1)/write(0)
memen  output  1  memory enable
memdone  input  1  memory completion

Behaviour:
- States: IDLE, ACCESS, RESP. Reset (sync, any state, including mid-ACCESS) forces:
  - state IDLE, count 0, lastgrant=I (data port wins the first tie)
  - iack=dack=err=0; irdata=drdata=0
  - memen=0, memrwb=1, membyteen=0000, memadr=0, memdata=Z
  - An aborted transaction is never acknowledged.
- memrwb=1 and membyteen=0000 in every state except ACCESS with a data write. The memory writes whenever rwb=0, so no glitch or idle write is permitted.
- IDLE:
  - No request: stay.
  - One request: grant it.
  - Both requesting: grant the port not in lastgrant, then update lastgrant.
  - On grant, latch address, rwb (instruction port always 1), write data and byteen (forced 0000 for reads). Go to ACCESS, count=0.
- ACCESS:
  - memen=1; memadr, memrwb and membyteen come from the latched values.
  - memdata is driven with latched wdata only when memrwb=0; otherwise Z.
  - count increments each cycle.
  - Qualified done = memdone & (count >= MINLAT-1). On qualified done: latch memdata into the granted port's rdata register (reads only; writes leave rdata unchanged), err<=0, go to RESP.
  - Otherwise, if count==TIMEOUT-1: err<=1, rdata unchanged, go to RESP.
- RESP:
  - memen=0, memrwb=1.
  - Exactly one of iack/dack is 1 for exactly this cycle, with err valid alongside it.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle t gives ack at cycle t+MINLAT+1 with zero-wait memory (memdone tied 1).
- Requester handshake: the requester must drop req the cycle after ack. If req is still high in the following IDLE, it is a new request. Request inputs are ignored outside IDLE; address and data changes after grant do not affect the transaction.
- Back-to-back with both ports requesting continuously: grants alternate D, I, D, I…, with one IDLE cycle between transactions.
- rdata registers hold their value until the next completed read on that port.

Test Plan:
- Reset, memdone=1, MINLAT=2, dreq write dadr=0x005 dwdata=0xA5A5A5A5 dbyteen=1111 -> memrwb=0 for 2 ACCESS cycles, dack pulse at t+3, err=0; memrwb=1 in all other cycles.
- ireq iadr=0x005 after that write -> irdata=0xA5A5A5A5 with iack, membyteen=0000 throughout, memrwb never 0.
- dreq write dbyteen=0010 dwdata=0x0000_3C00 to 0x005, then data read -> drdata=0xA5A53CA5.
- ireq and dreq held high from reset for 4 transactions -> grant order D, I, D, I; each ack one cycle wide; one IDLE cycle between transactions.
- memdone=0 constantly, TIMEOUT=16, dreq read -> dack with err=1 at ACCESS cycle 16, drdata unchanged, next transaction completes with err=0 once memdone=1.
- Assert reset during the 2nd ACCESS cycle of a write -> next cycle: memen=0, memrwb=1, no dack ever for that request; re-issued request completes normally.

Source files
------------

// File: rtl/extmem_arbiter.sv
// Purpose: round-robin arbiter/sequencer sharing one external memory between the instruction-fetch and data ports.
// Latency: request seen in IDLE at cycle t is acknowledged at t+MINLAT+1 with zero-wait memory; the ack is one cycle wide.
// Backpressure: a requester holds req until its ack; requests are sampled only in IDLE, and one transaction runs at a time.
//
// Ports:
//   ph1, reset                       clock (rising edge) and synchronous active-high reset
//   ireq, iadr -> iack, irdata       instruction read port; irdata holds the last completed instruction read
//   dreq, drwb, dadr, dwdata,        data port; drwb=1 read, 0 write; dbyteen bit0 selects data[7:0]
//   dbyteen -> dack, drdata
//   err                              qualifies iack/dack: 1 when the transaction timed out
//   memadr, memdata, membyteen,      external memory interface; memdata is bidirectional and is driven
//   memrwb, memen, memdone           here only during the ACCESS cycles of a write
module extmem_arbiter #(
    parameter int MINLAT  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        ireq,
    input  logic [12:0] iadr,
    output logic        iack,
    output logic [31:0] irdata,
    input  logic        dreq,
    input  logic        drwb,
    input  logic [12:0] dadr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dbyteen,
    output logic        dack,
    output logic [31:0] drdata,
    output logic        err,
    output logic [12:0] memadr,
    inout  wire  [31:0] memdata,
    output logic [3:0]  membyteen,
    output logic        memrwb,
    output logic        memen,
    input  logic        memdone
);

    // The ACCESS counter only has to reach TIMEOUT-1, where the transaction is abandoned.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] QUAL_CNT = CW'(MINLAT - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    port_t         lastgrant;
    port_t         owner;

    // Transaction captured at grant time; requester-side changes after grant are ignored.
    logic [12:0]   lat_adr;
    logic          lat_rwb;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_be;
    logic          err_q;

    logic          grant_vld;
    port_t         grant_port;
    logic          done_qual;
    logic          timeout_hit;

    // Round robin: on a tie the port that did not win last time is chosen.
    always_comb begin
        grant_vld  = ireq | dreq;
        grant_port = PORT_I;
        if (ireq && dreq) begin
            grant_port = (lastgrant == PORT_I) ? PORT_D : PORT_I;
        end else if (dreq) begin
            grant_port = PORT_D;
        end
    end

    // memdone is ignored until the memory has had MINLAT ACCESS cycles.
    assign done_qual   = memdone && (count >= QUAL_CNT);
    assign timeout_hit = (count == LAST_CNT);

    always_ff @(posedge ph1) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        memen     = 1'b0;
        memrwb    = 1'b1;
        membyteen = 4'b0000;
        memadr    = 13'd0;
        iack      = 1'b0;
        dack      = 1'b0;
        err       = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                memen     = 1'b1;
                memrwb    = lat_rwb;
                membyteen = lat_be;
                memadr    = lat_adr;
                if (done_qual || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                iack      = (owner == PORT_I);
                dack      = (owner == PORT_D);
                err       = err_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The bus is released whenever memrwb is high so the memory can drive read data.
    assign memdata = (state == ACCESS && !lat_rwb) ? lat_wdata : {32{1'bz}};

    always_ff @(posedge ph1) begin
        if (reset) begin
            count     <= '0;
            lastgrant <= PORT_I;
            owner     <= PORT_I;
            lat_adr   <= 13'd0;
            lat_rwb   <= 1'b1;
            lat_wdata <= 32'd0;
            lat_be    <= 4'b0000;
            err_q     <= 1'b0;
            irdata    <= 32'd0;
            drdata    <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner     <= grant_port;
                        lastgrant <= grant_port;
                        count     <= '0;
                        if (grant_port == PORT_D) begin
                            lat_adr   <= dadr;
                            lat_rwb   <= drwb;
                            lat_wdata <= dwdata;
                            // Reads must present no byte enables to the memory.
                            lat_be    <= drwb ? 4'b0000 : dbyteen;
                        end else begin
                            lat_adr   <= iadr;
                            lat_rwb   <= 1'b1;
                            lat_wdata <= 32'd0;
                            lat_be    <= 4'b0000;
                        end
                    end
                end
                ACCESS: begin
                    count <= count + 1'b1;
                    if (done_qual) begin
                        err_q <= 1'b0;
                        if (lat_rwb) begin
                            if (owner == PORT_I) begin
                                irdata <= memdata;
                            end else begin
                                drdata <= memdata;
                            end
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_extmem_arbiter.sv
// Purpose: self-checking bench for extmem_arbiter: directed scenarios plus randomized traffic against a transaction model.
// Latency: not applicable (bench); outputs are compared on every falling edge.
// Backpressure: requesters hold req until ack, then randomly drop or keep it as a new request.
module tb_extmem_arbiter;

    localparam int MINLAT  = 2;
    localparam int TIMEOUT = 16;

    logic        ph1;
    logic        reset;
    logic        ireq;
    logic [12:0] iadr;
    logic        iack;
    logic [31:0] irdata;
    logic        dreq;
    logic        drwb;
    logic [12:0] dadr;
    logic [31:0] dwdata;
    logic [3:0]  dbyteen;
    logic        dack;
    logic [31:0] drdata;
    logic        err;
    logic [12:0] memadr;
    wire  [31:0] memdata;
    logic [3:0]  membyteen;
    logic        memrwb;
    logic        memen;
    logic        memdone;

    int errors = 0;
    int checks = 0;

    extmem_arbiter #(.MINLAT(MINLAT), .TIMEOUT(TIMEOUT)) dut (
        .ph1(ph1), .reset(reset),
        .ireq(ireq), .iadr(iadr), .iack(iack), .irdata(irdata),
        .dreq(dreq), .drwb(drwb), .dadr(dadr), .dwdata(dwdata), .dbyteen(dbyteen),
        .dack(dack), .drdata(drdata), .err(err),
        .memadr(memadr), .memdata(memdata), .membyteen(membyteen),
        .memrwb(memrwb), .memen(memen), .memdone(memdone)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    // Memory device: drives read data combinationally, writes enabled bytes on every rising edge with rwb=0.
    logic [31:0] mem [0:8191];
    assign memdata = (memen && memrwb) ? mem[memadr] : {32{1'bz}};
    always @(posedge ph1) begin
        if (memen && !memrwb) begin
            for (int b = 0; b < 4; b++) begin
                if (membyteen[b]) mem[memadr][8*b +: 8] <= memdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding transaction, its age in ACCESS cycles, and whether it is responding.
    logic [31:0] ref_mem [0:8191];
    bit          m_busy = 1'b0;
    bit          m_resp = 1'b0;
    bit          m_err  = 1'b0;
    bit          m_port = 1'b0;   // 0 = instruction, 1 = data
    bit          m_last = 1'b0;
    bit          m_rd   = 1'b1;
    logic [12:0] m_adr  = 13'd0;
    logic [31:0] m_wd   = 32'd0;
    logic [3:0]  m_be   = 4'd0;
    int          m_age  = 0;
    logic [31:0] m_ir   = 32'd0;
    logic [31:0] m_dr   = 32'd0;
    bit          m_acc;

    initial begin
        forever begin
            @(negedge ph1);
            m_acc = m_busy && !m_resp;
            chk("iack", iack, m_resp && !m_port);
            chk("dack", dack, m_resp && m_port);
            if (m_resp) chk("err", err, m_err);
            chk("irdata", irdata, m_ir);
            chk("drdata", drdata, m_dr);
            chk("memen", memen, m_acc);
            chk("memrwb", memrwb, m_acc ? m_rd : 1'b1);
            chk("membyteen", membyteen, (m_acc && !m_rd) ? m_be : 4'd0);
            if (m_acc) chk("memadr", memadr, m_adr);
            if (m_acc && !m_rd) chk("memdata", memdata, m_wd);

            // Advance the model across the coming rising edge.
            if (m_acc && !m_rd) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_be[b]) ref_mem[m_adr][8*b +: 8] = m_wd[8*b +: 8];
                end
            end
            if (reset) begin
                m_busy = 1'b0; m_resp = 1'b0; m_last = 1'b0;
                m_ir = 32'd0; m_dr = 32'd0;
            end else if (!m_busy) begin
                if (ireq || dreq) begin
                    m_port = dreq && (!ireq || m_last == 1'b0);
                    m_last = m_port;
                    m_busy = 1'b1; m_resp = 1'b0; m_age = 0;
                    if (m_port) begin
                        m_adr = dadr; m_rd = drwb; m_wd = dwdata; m_be = dbyteen;
                    end else begin
                        m_adr = iadr; m_rd = 1'b1; m_wd = 32'd0; m_be = 4'd0;
                    end
                end
            end else if (!m_resp) begin
                m_age++;
                if (memdone && m_age >= MINLAT) begin
                    m_resp = 1'b1; m_err = 1'b0;
                    if (m_rd) begin
                        if (m_port) m_dr = ref_mem[m_adr];
                        else        m_ir = ref_mem[m_adr];
                    end
                end else if (m_age == TIMEOUT) begin
                    m_resp = 1'b1; m_err = 1'b1;
                end
            end else begin
                m_busy = 1'b0; m_resp = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge ph1);
        #2;
    endtask

    // Issue one request from IDLE, wait (bounded) for its ack, drop req and return to IDLE.
    task automatic do_req(input bit port, input bit rwb, input logic [12:0] adr,
                          input logic [31:0] wd, input logic [3:0] be,
                          output int lat, output logic e, output logic [31:0] rd,
                          output int wcyc, output int becyc);
        lat = 0; e = 1'b0; rd = 32'd0; wcyc = 0; becyc = 0;
        if (port) begin
            dreq = 1'b1; drwb = rwb; dadr = adr; dwdata = wd; dbyteen = be;
        end else begin
            ireq = 1'b1; iadr = adr;
        end
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (!memrwb) wcyc++;
            if (membyteen != 4'd0) becyc++;
            if (port ? dack : iack) begin
                lat = c; e = err; rd = port ? drdata : irdata;
                break;
            end
        end
        ireq = 1'b0; dreq = 1'b0;
        tick();
    endtask

    int          lat, wcyc, becyc, nack, pdone;
    logic        e;
    logic [31:0] rd, v;
    int          ack_port [4];
    int          ack_cyc  [4];

    initial begin
        reset = 1'b1; ireq = 1'b0; dreq = 1'b0; iadr = 13'd0; dadr = 13'd0;
        drwb = 1'b1; dwdata = 32'd0; dbyteen = 4'd0; memdone = 1'b1;
        for (int i = 0; i < 8192; i++) begin
            v = $urandom;
            mem[i] <= v;
            ref_mem[i] = v;
        end
        tick(); tick();
        chk("rst_memen", memen, 1'b0);
        chk("rst_memrwb", memrwb, 1'b1);
        chk("rst_membyteen", membyteen, 4'd0);
        chk("rst_memadr", memadr, 13'd0);
        chk("rst_iack", iack, 1'b0);
        chk("rst_dack", dack, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_irdata", irdata, 32'd0);
        chk("rst_drdata", drdata, 32'd0);
        reset = 1'b0;

        // Full-word write, then instruction read of the same word.
        do_req(1'b1, 1'b0, 13'h005, 32'hA5A5A5A5, 4'b1111, lat, e, rd, wcyc, becyc);
        chk("t1_latency", lat, 3);
        chk("t1_write_cycles", wcyc, 2);
        chk("t1_err", e, 1'b0);
        do_req(1'b0, 1'b1, 13'h005, 32'd0, 4'd0, lat, e, rd, wcyc, becyc);
        chk("t2_irdata", rd, 32'hA5A5A5A5);
        chk("t2_latency", lat, 3);
        chk("t2_write_cycles", wcyc, 0);
        chk("t2_byteen_cycles", becyc, 0);

        // Single-byte write merges into the existing word.
        do_req(1'b1, 1'b0, 13'h005, 32'h00003C00, 4'b0010, lat, e, rd, wcyc, becyc);
        do_req(1'b1, 1'b1, 13'h005, 32'hFFFFFFFF, 4'b1111, lat, e, rd, wcyc, becyc);
        chk("t3_drdata", rd, 32'hA5A53CA5);

        // Both ports requesting continuously from reset: D, I, D, I every 4 cycles.
        reset = 1'b1; tick(); reset = 1'b0;
        ireq = 1'b1; dreq = 1'b1; iadr = 13'h005; dadr = 13'h005; drwb = 1'b1;
        nack = 0;
        for (int c = 1; c <= 40 && nack < 4; c++) begin
            tick();
            if (iack || dack) begin
                ack_port[nack] = dack;
                ack_cyc[nack]  = c;
                nack++;
            end
        end
        ireq = 1'b0; dreq = 1'b0;
        tick();
        chk("t4_ack_count", nack, 4);
        for (int k = 0; k < 4 && k < nack; k++) begin
            chk("t4_grant_port", ack_port[k], (k % 2 == 0) ? 1 : 0);
            chk("t4_ack_cycle", ack_cyc[k], 3 + 4 * k);
        end

        // Timeout with a silent memory, then a normal completion.
        memdone = 1'b0;
        do_req(1'b1, 1'b1, 13'h003, 32'd0, 4'd0, lat, e, rd, wcyc, becyc);
        chk("t5_timeout_latency", lat, TIMEOUT + 1);
        chk("t5_timeout_err", e, 1'b1);
        chk("t5_drdata_kept", rd, 32'hA5A53CA5);
        memdone = 1'b1;
        do_req(1'b1, 1'b1, 13'h003, 32'd0, 4'd0, lat, e, rd, wcyc, becyc);
        chk("t5_recover_latency", lat, 3);
        chk("t5_recover_err", e, 1'b0);

        // Reset during the second ACCESS cycle of a write aborts it silently.
        dreq = 1'b1; drwb = 1'b0; dadr = 13'h007; dwdata = 32'h12345678; dbyteen = 4'b1111;
        tick(); tick();
        reset = 1'b1; dreq = 1'b0;
        tick();
        chk("t6_memen", memen, 1'b0);
        chk("t6_memrwb", memrwb, 1'b1);
        reset = 1'b0;
        nack = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (dack) nack++;
        end
        chk("t6_no_dack", nack, 0);
        do_req(1'b1, 1'b0, 13'h007, 32'h0BADF00D, 4'b1111, lat, e, rd, wcyc, becyc);
        chk("t6_reissue_latency", lat, 3);
        chk("t6_reissue_err", e, 1'b0);
        do_req(1'b0, 1'b1, 13'h007, 32'd0, 4'd0, lat, e, rd, wcyc, becyc);
        chk("t6_readback", rd, 32'h0BADF00D);

        // Randomized traffic; the model checks every cycle.
        pdone = 100;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 4))
                    0, 1:    pdone = 100;
                    2:       pdone = 70;
                    3:       pdone = 25;
                    default: pdone = 0;
                endcase
            end
            reset   = ($urandom_range(0, 299) == 0);
            memdone = ($urandom_range(1, 100) <= pdone);
            if (ireq) begin
                if (iack) ireq = $urandom_range(0, 1);
            end else begin
                ireq = ($urandom_range(0, 3) == 0);
            end
            if (dreq) begin
                if (dack) dreq = $urandom_range(0, 1);
            end else begin
                dreq = ($urandom_range(0, 3) == 0);
            end
            iadr    = 13'($urandom_range(0, 15));
            dadr    = 13'($urandom_range(0, 15));
            drwb    = $urandom_range(0, 1);
            dwdata  = $urandom;
            dbyteen = 4'($urandom_range(0, 15));
            tick();
        end

        reset = 1'b0; ireq = 1'b0; dreq = 1'b0; memdone = 1'b1;
        for (int c = 0; c < 24; c++) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
